pin_collector: RTL
==================

# pin_collector

Assembles keypad key events into a `pinPac_t` PIN packet and presents it, held, until the consumer acknowledges it. It is the producer side of the PIN-packet interface. It sits between the keypad decoder and the PIN consumers: master-PIN update, PIN compare and user-PIN programming. Unused digit slots are filled with the blank code `4'hE`, which consumers map to `0`.

## Interface

Parameters:
- `TIMEOUT_CYCLES`, default `100_000_000`: inactivity limit in clock cycles while collecting (2 s at 50 MHz).

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  block active; low forces IDLE and clears all state.
- `key_valid`  in  1  one-cycle strobe marking a new key.
- `key_code`  in  4  key value: `0`–`9` are digits, `4'hA` is `*` (clear), `4'hB` is `#` (submit), other values are ignored.
- `pin_ack`  in  1  consumer has taken the packet.
- `pin_out`  out  `pinPac_t`  fields `status`, `digit1`..`digit4`.
- `digit_count`  out  3  number of digits captured, 0–4.
- `busy`  out  1  high in COLLECT or PRESENT.
- `timeout`  out  1  one-cycle pulse when a collection is abandoned on inactivity.

## Operation

Reset values:
- `pin_out.status` = 0.
- All `pin_out` digits = `4'hE`.
- `digit_count` = 0, `busy` = 0, `timeout` = 0.
- State = IDLE.

States:
- IDLE
  - A digit key with `enable` high → COLLECT; the digit is written to `digit1` and `digit_count` becomes 1.
  - `*`, `#` and other codes are ignored.
- COLLECT
  - Digit key with `digit_count` < 4: the digit is written to slot `digit_count+1` and the count increments. Slots fill in order `digit1` → `digit4`.
  - Digit key with `digit_count` = 4: ignored; no shift and no overwrite.
  - `*`: all digits set to `4'hE`, count cleared, → IDLE.
  - `#` with `digit_count` ≥ 1: → PRESENT and `pin_out.status` goes to 1. Unfilled slots stay `4'hE`.
- PRESENT
  - `pin_out` is frozen; all key events are ignored.
  - `pin_ack` high: `status` → 0, digits → `4'hE`, count → 0, → IDLE.
- `enable` low in any state: next cycle is IDLE with reset values on all outputs. This takes priority over key, ack and timeout events in the same cycle.
- `busy` = (state ≠ IDLE).

## Timing

- All outputs are registered; a key accepted at edge N is visible after edge N.
- `#` accepted at edge N → `status` = 1 from edge N until the edge at which `pin_ack` is sampled high. `status` is 0 from the following cycle.
- `pin_ack` asserted while not in PRESENT is ignored. Acknowledge therefore requires `status` = 1 in the same cycle as `pin_ack`.
- Minimum PRESENT duration is 1 cycle (ack sampled on the first cycle status is high).
- `key_valid` is treated as a level each cycle. The upstream block guarantees single-cycle strobes; back-to-back strobes are accepted as separate keys.
- `rst` overrides everything at the next edge, including mid-collection and mid-PRESENT.

## Configuration

Macro `PIN_COLLECT_TIMEOUT_EN`.

Defined:
- An inactivity counter runs only in COLLECT.
- It clears on every accepted key, including ignored fifth digits.
- When the counter reaches `TIMEOUT_CYCLES`, the next cycle is IDLE with digits blanked and count 0. `timeout` pulses high for exactly that one cycle.
- A key arriving in the expiry cycle wins: it is accepted and the counter clears.
- Counter width is `$clog2(TIMEOUT_CYCLES+1)`.

Not defined:
- No counter logic is built and COLLECT persists indefinitely.
- `timeout` is tied to 0.

## Structure

- Shared package holds:
  - the `pinPac_t` typedef;
  - constants `DIGIT_BLANK = 4'hE`, `KEY_STAR = 4'hA`, `KEY_HASH = 4'hB`;
  - the state enum.
- Sub-module `inactivity_timer`:
  - inputs `clk`, `rst`, `run`, `restart`;
  - output `expired` pulse;
  - parameter `LIMIT`.
  - It is instantiated only under `PIN_COLLECT_TIMEOUT_EN`.

## Test plan

- Reset, then keys `1`,`2`,`3`,`4`,`#` → `pin_out` = {status 1, `1`,`2`,`3`,`4`}; hold 5 cycles; `pin_ack` → status 0, digits `E`, `busy` 0.
- Keys `7`,`#` → `pin_out` = {1, `7`,`E`,`E`,`E`} and `digit_count` = 1. Keys `5`,`6`,`7`,`8`,`9`,`#` → digits `5678`; the `9` is ignored.
- `#` in IDLE → no change. Keys `3`,`*` → IDLE, digits `E`. `*`,`#` in sequence → status stays 0.
- In PRESENT with digits `4321`: key `9` and `*` are ignored. Then drop `enable` together with `pin_ack` → reset values next cycle.
- With `PIN_COLLECT_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 20:
  - key `5`, then idle 20 cycles → `timeout` pulses once and digits are `E`;
  - a second run with a key on cycle 19 → no timeout.
- `rst` asserted mid-COLLECT (2 digits captured) → all outputs at reset values after one edge.

Source files
------------

// File: rtl/pin_collector_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pin_collector_pkg
// Brief    : Shared PIN-packet type, key codes and collector state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package pin_collector_pkg;

  localparam logic [3:0] DIGIT_BLANK = 4'hE;
  localparam logic [3:0] KEY_STAR    = 4'hA;
  localparam logic [3:0] KEY_HASH    = 4'hB;

  typedef struct packed {
    logic       status;
    logic [3:0] digit1;
    logic [3:0] digit2;
    logic [3:0] digit3;
    logic [3:0] digit4;
  } pinPac_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_PRESENT = 2'd2
  } pc_state_t;

  localparam pinPac_t c_pin_blank = '{
    status : 1'b0,
    digit1 : DIGIT_BLANK,
    digit2 : DIGIT_BLANK,
    digit3 : DIGIT_BLANK,
    digit4 : DIGIT_BLANK
  };

  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pin_collector_if.sv
`default_nettype none
// ============================================================================
// Module   : pin_collector_if
// Brief    : Key-event inputs and PIN-packet outputs of the collector.
// Revision : 1.0 - initial release
// ============================================================================
interface pin_collector_if;
  import pin_collector_pkg::*;

  logic       enable;
  logic       key_valid;
  logic [3:0] key_code;
  logic       pin_ack;
  pinPac_t    pin_out;
  logic [2:0] digit_count;
  logic       busy;
  logic       timeout;

  // master = packet producer (the collector), slave = keypad/consumer side
  modport master (
    input  enable, key_valid, key_code, pin_ack,
    output pin_out, digit_count, busy, timeout
  );

  modport slave (
    output enable, key_valid, key_code, pin_ack,
    input  pin_out, digit_count, busy, timeout
  );

endinterface
`default_nettype wire

// File: rtl/pin_collector_inactivity_timer.sv
`default_nettype none
// ============================================================================
// Module   : inactivity_timer
// Brief    : Saturating idle counter; flags expiry when LIMIT cycles elapse.
// Revision : 1.0 - initial release
// ============================================================================
module inactivity_timer #(
  parameter int unsigned LIMIT = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic restart,
  output logic expired
);

  localparam int unsigned      c_width = $clog2(LIMIT + 1);
  localparam logic [c_width-1:0] c_limit = c_width'(LIMIT);

  logic [c_width-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || !run || restart) begin
      r_cnt <= '0;
    end else if (r_cnt != c_limit) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // a restart in the expiry cycle suppresses the expiry
  assign expired = run && !restart && (r_cnt == c_limit);

endmodule
`default_nettype wire

// File: rtl/pin_collector.sv
`default_nettype none
// ============================================================================
// Module   : pin_collector
// Brief    : Assembles keypad digits into a pinPac_t packet and holds it until
//            acknowledged. Optional inactivity timeout: PIN_COLLECT_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pin_collector #(
  parameter int unsigned TIMEOUT_CYCLES = 100_000_000
) (
  input  logic            clk,
  input  logic            rst,
  pin_collector_if.master bus
);
  import pin_collector_pkg::*;

  pc_state_t  r_state,   w_state_nxt;
  pinPac_t    r_pin,     w_pin_nxt;
  logic [2:0] r_count,   w_count_nxt;
  logic       r_timeout, w_timeout_nxt;
  logic       w_expired;

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("pin_collector: TIMEOUT_CYCLES must be non-zero");
  end

`ifdef PIN_COLLECT_TIMEOUT_EN
  inactivity_timer #(
    .LIMIT   (TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .run     (r_state == ST_COLLECT),
    .restart (bus.key_valid),
    .expired (w_expired)
  );
`else
  assign w_expired = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_pin     <= c_pin_blank;
      r_count   <= 3'd0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pin     <= w_pin_nxt;
      r_count   <= w_count_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_pin_nxt     = r_pin;
    w_count_nxt   = r_count;
    w_timeout_nxt = 1'b0;

    if (!bus.enable) begin
      w_state_nxt = ST_IDLE;
      w_pin_nxt   = c_pin_blank;
      w_count_nxt = 3'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.key_valid && is_digit(bus.key_code)) begin
            w_pin_nxt.digit1 = bus.key_code;
            w_count_nxt      = 3'd1;
            w_state_nxt      = ST_COLLECT;
          end
        end

        ST_COLLECT: begin
          if (bus.key_valid) begin
            if (is_digit(bus.key_code)) begin
              // a fifth digit falls through the default and is dropped
              case (r_count)
                3'd0:    w_pin_nxt.digit1 = bus.key_code;
                3'd1:    w_pin_nxt.digit2 = bus.key_code;
                3'd2:    w_pin_nxt.digit3 = bus.key_code;
                3'd3:    w_pin_nxt.digit4 = bus.key_code;
                default: ;
              endcase
              if (r_count < 3'd4) begin
                w_count_nxt = r_count + 3'd1;
              end
            end else if (bus.key_code == KEY_STAR) begin
              w_pin_nxt   = c_pin_blank;
              w_count_nxt = 3'd0;
              w_state_nxt = ST_IDLE;
            end else if (bus.key_code == KEY_HASH && r_count != 3'd0) begin
              w_pin_nxt.status = 1'b1;
              w_state_nxt      = ST_PRESENT;
            end
          end else if (w_expired) begin
            w_pin_nxt     = c_pin_blank;
            w_count_nxt   = 3'd0;
            w_state_nxt   = ST_IDLE;
            w_timeout_nxt = 1'b1;
          end
        end

        ST_PRESENT: begin
          if (bus.pin_ack) begin
            w_pin_nxt   = c_pin_blank;
            w_count_nxt = 3'd0;
            w_state_nxt = ST_IDLE;
          end
        end

        default: begin
          w_pin_nxt   = c_pin_blank;
          w_count_nxt = 3'd0;
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  assign bus.pin_out     = r_pin;
  assign bus.digit_count = r_count;
  assign bus.busy        = (r_state != ST_IDLE);
  assign bus.timeout     = r_timeout;

endmodule
`default_nettype wire
